// File: rtl/regfile_scoreboard_if.sv
// Register-file access bundle: two read ports with busy flags, writeback port, and the
// decode claim handshake. master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int WORD = 64,
    parameter int AW   = 5
);
    logic [AW-1:0]   rd_addr_1;
    logic [AW-1:0]   rd_addr_2;
    logic [WORD-1:0] rd_data_1;
    logic [WORD-1:0] rd_data_2;
    logic            busy_1;
    logic            busy_2;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [WORD-1:0] wr_data;
    logic            claim_en;
    logic [AW-1:0]   claim_addr;
    logic            claim_ack;

    modport master (
        output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_data_1, rd_data_2, busy_1, busy_2, claim_ack
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        output rd_data_1, rd_data_2, busy_1, busy_2, claim_ack
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with combinational reads, optional writeback forwarding, a hardwired zero
// register and a per-register busy scoreboard (decode claims, writeback releases).
module regfile_scoreboard #(
    parameter int WORD     = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input logic                clk,
    input logic                reset,
    regfile_scoreboard_if.slave rf
);
    localparam int AW = $clog2(NUM_REGS);
    // One bit wider than an address so ZERO_REG == NUM_REGS never matches.
    localparam logic [AW:0] ZERO_IDX = (AW+1)'(ZERO_REG);

    logic [WORD-1:0]     regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                wr_valid;
    logic                claim_zero;
    logic                ack_now;

    assign wr_valid   = rf.wr_en && ({1'b0, rf.wr_addr} != ZERO_IDX);
    assign claim_zero = ({1'b0, rf.claim_addr} == ZERO_IDX);

    // A writeback releasing the same register this cycle lets the claim through.
    always_comb begin
        ack_now = 1'b0;
        if (rf.claim_en && !reset) begin
            ack_now = claim_zero || !busy_q[rf.claim_addr]
                      || (rf.wr_en && (rf.wr_addr == rf.claim_addr));
        end
    end

    assign rf.claim_ack = ack_now;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign regs_q[gi] = '0;
                assign busy_q[gi] = 1'b0;
            end else begin : g_live
                logic [WORD-1:0] data_reg;
                logic            busy_reg;
                logic            hit_wr;
                logic            hit_claim;

                assign hit_wr    = wr_valid && (rf.wr_addr == AW'(gi));
                assign hit_claim = ack_now && (rf.claim_addr == AW'(gi));

                // A new claim outranks the release from a same-cycle writeback.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        if (hit_wr) begin
                            data_reg <= rf.wr_data;
                        end
                        if (hit_claim) begin
                            busy_reg <= 1'b1;
                        end else if (hit_wr) begin
                            busy_reg <= 1'b0;
                        end
                    end
                end

                assign regs_q[gi] = data_reg;
                assign busy_q[gi] = busy_reg;
            end
        end
    endgenerate

    always_comb begin
        rf.rd_data_1 = regs_q[rf.rd_addr_1];
        rf.busy_1    = busy_q[rf.rd_addr_1];
        if ((BYPASS != 0) && wr_valid && (rf.wr_addr == rf.rd_addr_1)) begin
            rf.rd_data_1 = rf.wr_data;
            rf.busy_1    = 1'b0;
        end
    end

    always_comb begin
        rf.rd_data_2 = regs_q[rf.rd_addr_2];
        rf.busy_2    = busy_q[rf.rd_addr_2];
        if ((BYPASS != 0) && wr_valid && (rf.wr_addr == rf.rd_addr_2)) begin
            rf.rd_data_2 = rf.wr_data;
            rf.busy_2    = 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a forwarding and a non-forwarding instance share stimulus;
// expected values are queued when inputs are driven and compared at the following negedge.
module tb_regfile_scoreboard;
    logic clk;
    logic reset;

    regfile_scoreboard_if #(.WORD(64), .AW(5)) bus_byp ();
    regfile_scoreboard_if #(.WORD(64), .AW(5)) bus_nb ();

    assign bus_nb.rd_addr_1  = bus_byp.rd_addr_1;
    assign bus_nb.rd_addr_2  = bus_byp.rd_addr_2;
    assign bus_nb.wr_en      = bus_byp.wr_en;
    assign bus_nb.wr_addr    = bus_byp.wr_addr;
    assign bus_nb.wr_data    = bus_byp.wr_data;
    assign bus_nb.claim_en   = bus_byp.claim_en;
    assign bus_nb.claim_addr = bus_byp.claim_addr;

    regfile_scoreboard #(.WORD(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(1)) u_dut_byp (
        .clk   (clk),
        .reset (reset),
        .rf    (bus_byp.slave)
    );

    regfile_scoreboard #(.WORD(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .rf    (bus_nb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] m_regs [32];
    bit          m_busy [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd31) return 64'd0;
        if (byp && bus_byp.wr_en && (bus_byp.wr_addr == a)) return bus_byp.wr_data;
        return m_regs[a];
    endfunction

    function automatic logic [63:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd31) return 64'd0;
        if (byp && bus_byp.wr_en && (bus_byp.wr_addr == a)) return 64'd0;
        return 64'(m_busy[a]);
    endfunction

    function automatic bit exp_ack();
        if (!bus_byp.claim_en || reset) return 1'b0;
        return (bus_byp.claim_addr == 5'd31) || !m_busy[bus_byp.claim_addr]
               || (bus_byp.wr_en && (bus_byp.wr_addr == bus_byp.claim_addr));
    endfunction

    task automatic model_update();
        bit ack;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            ack = exp_ack();
            if (bus_byp.wr_en && (bus_byp.wr_addr != 5'd31)) begin
                m_regs[bus_byp.wr_addr] = bus_byp.wr_data;
                m_busy[bus_byp.wr_addr] = 1'b0;
            end
            if (ack && (bus_byp.claim_addr != 5'd31)) m_busy[bus_byp.claim_addr] = 1'b1;
        end
    endtask

    task automatic set_in(input logic [4:0] ra1, input logic [4:0] ra2, input logic wen,
                          input logic [4:0] wa, input logic [63:0] wd,
                          input logic cen, input logic [4:0] ca);
        bus_byp.rd_addr_1  = ra1;
        bus_byp.rd_addr_2  = ra2;
        bus_byp.wr_en      = wen;
        bus_byp.wr_addr    = wa;
        bus_byp.wr_data    = wd;
        bus_byp.claim_en   = cen;
        bus_byp.claim_addr = ca;
    endtask

    // One transaction: queue expectations, compare at negedge, advance the model at posedge.
    task automatic cycle(input string tag);
        logic [63:0] obs [8];
        exp_t        e;
        sb_q.push_back('{{tag, ":rd1"},    exp_rd(bus_byp.rd_addr_1, 1'b1)});
        sb_q.push_back('{{tag, ":rd2"},    exp_rd(bus_byp.rd_addr_2, 1'b1)});
        sb_q.push_back('{{tag, ":busy1"},  exp_busy(bus_byp.rd_addr_1, 1'b1)});
        sb_q.push_back('{{tag, ":busy2"},  exp_busy(bus_byp.rd_addr_2, 1'b1)});
        sb_q.push_back('{{tag, ":ack"},    64'(exp_ack())});
        sb_q.push_back('{{tag, ":nb_rd1"}, exp_rd(bus_byp.rd_addr_1, 1'b0)});
        sb_q.push_back('{{tag, ":nb_bsy1"}, exp_busy(bus_byp.rd_addr_1, 1'b0)});
        sb_q.push_back('{{tag, ":nb_ack"}, 64'(exp_ack())});
        @(negedge clk);
        obs[0] = bus_byp.rd_data_1;
        obs[1] = bus_byp.rd_data_2;
        obs[2] = 64'(bus_byp.busy_1);
        obs[3] = 64'(bus_byp.busy_2);
        obs[4] = 64'(bus_byp.claim_ack);
        obs[5] = bus_nb.rd_data_1;
        obs[6] = 64'(bus_nb.busy_1);
        obs[7] = 64'(bus_nb.claim_ack);
        for (int i = 0; i < 8; i++) begin
            if (sb_q.size() == 0) begin
                check({tag, ":sb_empty"}, 64'd0, 64'd1);
                break;
            end
            e = sb_q.pop_front();
            check(e.tag, obs[i], e.val);
        end
        $display("txn %-12s ra1=%0d ra2=%0d wr=%0b@%0d claim=%0b@%0d rst=%0b rd1=%h ack=%0b",
                 tag, bus_byp.rd_addr_1, bus_byp.rd_addr_2, bus_byp.wr_en, bus_byp.wr_addr,
                 bus_byp.claim_en, bus_byp.claim_addr, reset, obs[0], obs[4][0]);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        logic [4:0] a1, a2, wa, ca;
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        @(posedge clk);
        model_update();
        #1;

        // Reset: claim refused while reset is high.
        set_in(5'd3, 5'd3, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
        cycle("rst_ack");
        reset = 1'b0;
        set_in(5'd3, 5'd3, 1'b1, 5'd3, 64'd5, 1'b0, 5'd0);
        cycle("wr_x3");
        reset = 1'b1;
        set_in(5'd3, 5'd3, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3);
        cycle("rst_pulse");
        reset = 1'b0;
        set_in(5'd3, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("after_rst");

        // Write then read on both ports.
        set_in(5'd0, 5'd1, 1'b1, 5'd7, 64'h3456789ABCDEF012, 1'b0, 5'd0);
        cycle("wr_x7");
        set_in(5'd7, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("rd_x7");

        // Same-cycle forwarding vs none.
        set_in(5'd9, 5'd9, 1'b1, 5'd9, 64'd981, 1'b0, 5'd0);
        cycle("byp_x9");
        set_in(5'd9, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("rd_x9");

        // Claim, refused reclaim, writeback release.
        set_in(5'd4, 5'd4, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4);
        cycle("claim_x4");
        set_in(5'd4, 5'd4, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4);
        cycle("reclaim_x4");
        set_in(5'd4, 5'd4, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 5'd0);
        cycle("wb_x4");
        set_in(5'd4, 5'd4, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("x4_free");

        // Write and claim same register: new producer wins.
        set_in(5'd4, 5'd4, 1'b1, 5'd4, 64'd77, 1'b1, 5'd4);
        cycle("wrclm_x4");
        set_in(5'd4, 5'd4, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("x4_busy");
        // Busy register: claim acked only because writeback releases it this cycle.
        set_in(5'd4, 5'd4, 1'b1, 5'd4, 64'd99, 1'b1, 5'd4);
        cycle("retry_x4");

        // Zero register, then reset during a pending claim.
        set_in(5'd31, 5'd31, 1'b1, 5'd31, 64'd345, 1'b1, 5'd31);
        cycle("x31_wrclm");
        set_in(5'd31, 5'd2, 1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
        cycle("claim_x2");
        reset = 1'b1;
        set_in(5'd2, 5'd2, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("rst_x2");
        reset = 1'b0;
        set_in(5'd2, 5'd4, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        cycle("x2_clear");

        // Random traffic over a small address window to force collisions.
        for (int n = 0; n < 60; n++) begin
            a1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            wa = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ca = 5'($urandom_range(0, 7));
            set_in(a1, a2, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), ca);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
